int_div_seq: RTL

//  Parametrised sequential integer divider for the RISC-V M-extension ALU (DIV/DIVU/REM/REMU).

---
 rtl/int_div_seq_if.sv | 28 ++
 rtl/int_div_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/int_div_seq_if.sv
// Request/response bundle for the sequential integer divider.
// Both sides use valid/ready handshakes. A transfer happens on a rising edge where valid and ready are
// both high. The sender keeps its payload stable while valid is high and ready is low.
// For requests, the requester drives valid/op/a/b and the divider drives ready.
// For responses, the divider drives res_valid/result and the consumer drives res_ready.
interface int_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output valid, op, a, b, flush, res_ready,
    input  ready, res_valid, result
  );

  modport slave (
    input  valid, op, a, b, flush, res_ready,
    output ready, res_valid, result
  );
endinterface

// File: rtl/int_div_seq.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle on operand magnitudes.
// Divide-by-zero and signed overflow are resolved at accept and skip the iteration loop.
module int_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  int_div_seq_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               rem_sel_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept;
  logic               is_signed;
  logic               b_zero;
  logic               ovf;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last;

  assign accept    = bus.valid && (state_q == S_IDLE) && !bus.flush;
  assign is_signed = ~bus.op[0];
  assign b_zero    = (bus.b == '0);
  assign ovf       = is_signed && (bus.a == MIN_VAL) && (&bus.b);
  // Unsigned negation of MIN yields 2^(WIDTH-1), so |MIN| is exact in WIDTH unsigned bits.
  assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The shifted partial remainder needs WIDTH+1 bits when the divisor is above 2^(WIDTH-1).
  assign trial    = {rem_q, a_q[WIDTH-1]};
  assign diff     = trial - {1'b0, b_q};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {a_q[WIDTH-2:0], q_bit};
  assign quo_fix  = neg_q_q ? -quo_next : quo_next;
  assign rem_fix  = neg_r_q ? -rem_next : rem_next;
  assign last     = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (b_zero || ovf) ? S_DONE : S_CALC;
      S_CALC:  if (last) state_d = S_DONE;
      S_DONE:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        rem_sel_q <= bus.op[1];
        neg_q_q   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r_q   <= is_signed && bus.a[WIDTH-1];
        cnt_q     <= '0;
        a_q       <= a_mag;
        b_q       <= b_mag;
        rem_q     <= '0;
        if (b_zero)   result_q <= bus.op[1] ? bus.a : '1;
        else if (ovf) result_q <= bus.op[1] ? '0 : MIN_VAL;
      end else if (state_q == S_CALC) begin
        a_q   <= quo_next;
        rem_q <= rem_next;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) result_q <= rem_sel_q ? rem_fix : quo_fix;
      end
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign dbg_state     = state_q;
endmodule
